// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC prediction
// from predecode, and the IF/ID pipeline register.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  input  logic        stall_if_i,
  input  logic        ex_redirect_i,
  input  logic [31:0] ex_redirect_pc_i,
  input  logic        prediction_hazard_i,
  output logic [4:0]  prediction_Rs1_id_o,
  output logic [4:0]  prediction_Rs2_id_o,
  input  logic [31:0] prediction_Rs1_data_id_i,
  input  logic [31:0] prediction_Rs2_data_id_i,
  output logic [31:0] instr_if_o,
  output logic [31:0] pc_if_o,
  output logic        valid_if_o,
  output logic        pred_taken_if_o,
  output logic [31:0] pred_target_if_o,
  output logic [31:0] redirect_cnt_o
);

  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR   = 7'b1100011;

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcif_q, pcif_d;
  logic        valid_q, valid_d;
  logic        tk_q, tk_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] cnt_q, cnt_d;

  logic [31:0] ins;
  logic [31:0] rs1, rs2;
  logic [31:0] imm_j, imm_i, imm_b;
  logic [31:0] pc_plus4;
  logic [2:0]  f3;
  logic        is_jal, is_jalr, is_br;
  logic        br_cond;
  logic        pred_tk;
  logic [31:0] pred_tgt;

  assign ins   = imem_instr_i;
  assign rs1   = prediction_Rs1_data_id_i;
  assign rs2   = prediction_Rs2_data_id_i;
  assign f3    = ins[14:12];
  assign imm_j = {{12{ins[31]}}, ins[19:12], ins[20],
                  ins[30:21], 1'b0};
  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_b = {{20{ins[31]}}, ins[7], ins[30:25],
                  ins[11:8], 1'b0};

  assign pc_plus4 = pc_q + 32'd4;
  assign is_jal   = ins[6:0] == OP_JAL;
  assign is_jalr  = ins[6:0] == OP_JALR;
  assign is_br    = ins[6:0] == OP_BR;

  assign imem_addr_o         = pc_q;
  assign prediction_Rs1_id_o = ins[19:15];
  assign prediction_Rs2_id_o = ins[24:20];

  always_comb begin
    br_cond = 1'b0;
    case (f3)
      3'b000: br_cond = rs1 == rs2;
      3'b001: br_cond = rs1 != rs2;
      3'b100: br_cond = $signed(rs1) < $signed(rs2);
      3'b101: br_cond = $signed(rs1) >= $signed(rs2);
      3'b110: br_cond = rs1 < rs2;
      3'b111: br_cond = rs1 >= rs2;
      default: br_cond = 1'b0;
    endcase
  end

  always_comb begin
    pred_tk  = 1'b0;
    pred_tgt = pc_plus4;
    unique case (1'b1)
      is_jal: begin
        pred_tk  = 1'b1;
        pred_tgt = pc_q + imm_j;
      end
      is_jalr: begin
        if (!prediction_hazard_i) begin
          pred_tk  = 1'b1;
          pred_tgt = (rs1 + imm_i) & ~32'h1;
        end
      end
      is_br: begin
        // Untrusted operands fall back to backward-taken.
        pred_tk = prediction_hazard_i ? ins[31] : br_cond;
        if (pred_tk) pred_tgt = pc_q + imm_b;
      end
      default: ;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pcif_d  = pcif_q;
    valid_d = valid_q;
    tk_d    = tk_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    if (ex_redirect_i) begin
      pc_d    = ex_redirect_pc_i;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      tk_d    = 1'b0;
      cnt_d   = cnt_q + 32'd1;
    end else if (!stall_if_i) begin
      pc_d    = pred_tgt;
      instr_d = ins;
      pcif_d  = pc_q;
      valid_d = 1'b1;
      tk_d    = pred_tk;
      tgt_d   = pred_tgt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pcif_q  <= 32'd0;
      valid_q <= 1'b0;
      tk_q    <= 1'b0;
      tgt_q   <= 32'd0;
      cnt_q   <= 32'd0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcif_q  <= pcif_d;
      valid_q <= valid_d;
      tk_q    <= tk_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign instr_if_o       = instr_q;
  assign pc_if_o          = pcif_q;
  assign valid_if_o       = valid_q;
  assign pred_taken_if_o  = tk_q;
  assign pred_target_if_o = tgt_q;
  assign redirect_cnt_o   = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: vector table for predecode,
// hand sequences for reset, stall and redirect.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_instr_i;
  logic        stall_if_i;
  logic        ex_redirect_i;
  logic [31:0] ex_redirect_pc_i;
  logic        prediction_hazard_i;
  logic [4:0]  rs1_id, rs2_id;
  logic [31:0] rs1_data, rs2_data;
  logic [31:0] instr_if_o, pc_if_o;
  logic        valid_if_o, pred_taken_if_o;
  logic [31:0] pred_target_if_o, redirect_cnt_o;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_cnt = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_addr_o(imem_addr_o),
    .imem_instr_i(imem_instr_i),
    .stall_if_i(stall_if_i),
    .ex_redirect_i(ex_redirect_i),
    .ex_redirect_pc_i(ex_redirect_pc_i),
    .prediction_hazard_i(prediction_hazard_i),
    .prediction_Rs1_id_o(rs1_id),
    .prediction_Rs2_id_o(rs2_id),
    .prediction_Rs1_data_id_i(rs1_data),
    .prediction_Rs2_data_id_i(rs2_data),
    .instr_if_o(instr_if_o),
    .pc_if_o(pc_if_o),
    .valid_if_o(valid_if_o),
    .pred_taken_if_o(pred_taken_if_o),
    .pred_target_if_o(pred_target_if_o),
    .redirect_cnt_o(redirect_cnt_o)
  );

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        hz;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] nxt;
    logic        tk;
  } vec_t;

  vec_t vt[$];

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(string nm, logic [31:0] pc,
      logic [31:0] ins, logic hz, logic [31:0] r1,
      logic [31:0] r2, logic [31:0] nxt, logic tk);
    vec_t v;
    v.name = nm; v.pc = pc; v.instr = ins; v.hz = hz;
    v.r1 = r1; v.r2 = r2; v.nxt = nxt; v.tk = tk;
    return v;
  endfunction

  initial begin
    vt.push_back(mk("jal+16", 32'h10, 32'h0100006F,
                    0, 0, 0, 32'h20, 1));
    vt.push_back(mk("beq_hz", 32'h40, 32'hFE208CE3,
                    1, 0, 0, 32'h38, 1));
    vt.push_back(mk("beq_ne", 32'h40, 32'hFE208CE3,
                    0, 5, 6, 32'h44, 0));
    vt.push_back(mk("beq_eq", 32'h40, 32'hFE208CE3,
                    0, 7, 7, 32'h38, 1));
    vt.push_back(mk("jalr", 32'h80, 32'h00008067,
                    0, 32'h103, 0, 32'h102, 1));
    vt.push_back(mk("jalr_hz", 32'h80, 32'h00008067,
                    1, 32'h103, 0, 32'h84, 0));
    vt.push_back(mk("jalr_imm", 32'h80, 32'h00408067,
                    0, 32'h1000, 0, 32'h1004, 1));
    vt.push_back(mk("bne", 32'h40, 32'hFE209CE3,
                    0, 5, 6, 32'h38, 1));
    vt.push_back(mk("blt", 32'h40, 32'hFE20CCE3,
                    0, 32'hFFFFFFFF, 1, 32'h38, 1));
    vt.push_back(mk("bltu", 32'h40, 32'hFE20ECE3,
                    0, 32'hFFFFFFFF, 1, 32'h44, 0));
    vt.push_back(mk("bge", 32'h40, 32'hFE20DCE3,
                    0, 32'hFFFFFFFF, 1, 32'h44, 0));
    vt.push_back(mk("bgeu", 32'h40, 32'hFE20FCE3,
                    0, 32'hFFFFFFFF, 1, 32'h38, 1));
    vt.push_back(mk("f3_010", 32'h40, 32'hFE20ACE3,
                    0, 3, 3, 32'h44, 0));
    vt.push_back(mk("fwd_hz", 32'h40, 32'h00208463,
                    1, 0, 0, 32'h44, 0));
    vt.push_back(mk("fwd_tk", 32'h40, 32'h00208463,
                    0, 9, 9, 32'h48, 1));
    vt.push_back(mk("addi", 32'h60, 32'h00000013,
                    0, 0, 0, 32'h64, 0));
    vt.push_back(mk("jal_wrap", 32'hFFFFFFF0, 32'h0100006F,
                    0, 0, 0, 32'h0, 1));
    vt.push_back(mk("pc4_wrap", 32'hFFFFFFFC, 32'h00000013,
                    0, 0, 0, 32'h0, 0));
    vt.push_back(mk("jal-4", 32'h100, 32'hFFDFF06F,
                    0, 0, 0, 32'hFC, 1));

    rst_n = 1'b0;
    imem_instr_i = 32'h13;
    stall_if_i = 0;
    ex_redirect_i = 0;
    ex_redirect_pc_i = 0;
    prediction_hazard_i = 0;
    rs1_data = 0;
    rs2_data = 0;

    #12;
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_instr", instr_if_o, 32'h13);
    chk("rst_valid", {31'd0, valid_if_o}, 32'd0);
    chk("rst_cnt", redirect_cnt_o, 32'd0);
    chk("rst_tgt", pred_target_if_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_addr0", imem_addr_o, 32'h0);
    tick();
    chk("rel_addr4", imem_addr_o, 32'h4);
    chk("rel_valid", {31'd0, valid_if_o}, 32'd1);
    chk("rel_pcif", pc_if_o, 32'h0);
    tick();
    chk("rel_addr8", imem_addr_o, 32'h8);
    chk("rel_pcif4", pc_if_o, 32'h4);

    foreach (vt[k]) begin
      ex_redirect_i = 1;
      ex_redirect_pc_i = vt[k].pc;
      tick();
      exp_cnt++;
      chk({vt[k].name, "_rdpc"}, imem_addr_o, vt[k].pc);
      chk({vt[k].name, "_bub"}, {31'd0, valid_if_o}, 32'd0);
      chk({vt[k].name, "_cnt"}, redirect_cnt_o, exp_cnt);
      ex_redirect_i = 0;
      imem_instr_i = vt[k].instr;
      prediction_hazard_i = vt[k].hz;
      rs1_data = vt[k].r1;
      rs2_data = vt[k].r2;
      tick();
      chk({vt[k].name, "_next"}, imem_addr_o, vt[k].nxt);
      chk({vt[k].name, "_tk"}, {31'd0, pred_taken_if_o},
          {31'd0, vt[k].tk});
      chk({vt[k].name, "_tgt"}, pred_target_if_o, vt[k].nxt);
      chk({vt[k].name, "_pcif"}, pc_if_o, vt[k].pc);
      chk({vt[k].name, "_ins"}, instr_if_o, vt[k].instr);
      chk({vt[k].name, "_val"}, {31'd0, valid_if_o}, 32'd1);
    end

    imem_instr_i = 32'hFE208CE3;
    #1;
    chk("rs1_id", {27'd0, rs1_id}, 32'd1);
    chk("rs2_id", {27'd0, rs2_id}, 32'd2);

    // Stall three cycles, then redirect while still stalled.
    ex_redirect_i = 1;
    ex_redirect_pc_i = 32'h300;
    imem_instr_i = 32'h13;
    tick();
    exp_cnt++;
    ex_redirect_i = 0;
    tick();
    chk("st_pre_addr", imem_addr_o, 32'h304);
    stall_if_i = 1;
    imem_instr_i = 32'h0100006F;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("st_addr", imem_addr_o, 32'h304);
      chk("st_pcif", pc_if_o, 32'h300);
      chk("st_instr", instr_if_o, 32'h13);
      chk("st_valid", {31'd0, valid_if_o}, 32'd1);
    end
    ex_redirect_i = 1;
    ex_redirect_pc_i = 32'h200;
    tick();
    exp_cnt++;
    chk("st_rd_addr", imem_addr_o, 32'h200);
    chk("st_rd_valid", {31'd0, valid_if_o}, 32'd0);
    chk("st_rd_instr", instr_if_o, 32'h13);
    chk("st_rd_cnt", redirect_cnt_o, exp_cnt);
    ex_redirect_i = 0;
    stall_if_i = 0;
    imem_instr_i = 32'h13;
    tick();
    chk("post_addr", imem_addr_o, 32'h204);
    chk("post_pcif", pc_if_o, 32'h200);

    // Asynchronous reset between edges.
    imem_instr_i = 32'h0100006F;
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_addr", imem_addr_o, 32'h0);
    chk("ar_valid", {31'd0, valid_if_o}, 32'd0);
    chk("ar_tk", {31'd0, pred_taken_if_o}, 32'd0);
    chk("ar_tgt", pred_target_if_o, 32'd0);
    chk("ar_pcif", pc_if_o, 32'd0);
    chk("ar_instr", instr_if_o, 32'h13);
    chk("ar_cnt", redirect_cnt_o, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
